// File: rtl/softmax_stream_pkg.sv
// Shared types and default geometry for the softmax row streamer.
// Build option: SOFTMAX_ROW_STREAMER_DBUF_EN adds a one-deep pending matrix buffer.
package softmax_stream_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MATRIX_ROWS = 128;
  localparam int DEF_MATRIX_COLS = 128;
  localparam int ROW_W = DEF_DATA_WIDTH * DEF_MATRIX_COLS;
  localparam int MAT_W = ROW_W * DEF_MATRIX_ROWS;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/matrix_capture_buffer.sv
// Active shift buffer (row 0 in the low bits) plus the optional pending matrix.
// Build option: SOFTMAX_ROW_STREAMER_DBUF_EN enables the pending buffer.
module matrix_capture_buffer #(
  parameter int  ROW_BITS    = softmax_stream_pkg::ROW_W,
  parameter int  MATRIX_ROWS = softmax_stream_pkg::DEF_MATRIX_ROWS,
  localparam int MAT_BITS    = ROW_BITS * MATRIX_ROWS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MAT_BITS-1:0] matrix,
  input  logic                load_in,
  input  logic                load_pend,
  input  logic                shift,
  input  logic                pend_wr,
  input  logic                pend_clr,
  output logic [ROW_BITS-1:0] row_data,
  output logic                pending_full
);

  logic [MAT_BITS-1:0] active;
  logic [MAT_BITS-1:0] pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
    end else if (load_in) begin
      active <= matrix;
    end else if (load_pend) begin
      active <= pending;
    end else if (shift) begin
      active <= active >> ROW_BITS;
    end
  end

  assign row_data = active[ROW_BITS-1:0];

`ifdef SOFTMAX_ROW_STREAMER_DBUF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      pending_full <= 1'b0;
    end else if (pend_wr) begin
      pending      <= matrix;
      pending_full <= 1'b1;
    end else if (pend_clr) begin
      pending_full <= 1'b0;
    end
  end
`else
  logic unused_pend_ctrl;
  assign unused_pend_ctrl = ^{pend_wr, pend_clr};
  assign pending      = '0;
  assign pending_full = 1'b0;
`endif

endmodule

// File: rtl/softmax_row_streamer.sv
// Captures a flattened matrix on a falling edge of matrix_valid_n and streams it row by row.
// Build option: SOFTMAX_ROW_STREAMER_DBUF_EN queues one extra matrix while streaming.
module softmax_row_streamer
  import softmax_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MATRIX_ROWS   = DEF_MATRIX_ROWS,
  parameter int MATRIX_COLS   = DEF_MATRIX_COLS,
  parameter int ROW_IDX_WIDTH = (MATRIX_ROWS > 1) ? $clog2(MATRIX_ROWS) : 1
) (
  input  logic                                      clk_p,
  input  logic                                      rst_p,
  input  logic [DATA_WIDTH*MATRIX_ROWS*MATRIX_COLS-1:0] matrix,
  input  logic                                      matrix_valid_n,
  output logic                                      in_ready,
  output logic [DATA_WIDTH*MATRIX_COLS-1:0]         row_data,
  output logic [ROW_IDX_WIDTH-1:0]                  row_idx,
  output logic                                      row_last,
  output logic                                      row_valid,
  input  logic                                      row_ready,
  output logic                                      busy,
  output logic                                      overflow,
  output state_t                                    dbg_state
);

  localparam int ROW_BITS = DATA_WIDTH * MATRIX_COLS;
  localparam logic [ROW_IDX_WIDTH-1:0] LAST_IDX = ROW_IDX_WIDTH'(MATRIX_ROWS - 1);

  state_t state;
  logic   valid_n_q;
  logic   pending_full;
  logic   capture_edge, handshake, last_hs, accept;
  logic   load_in, load_pend, shift, pend_wr, pend_clr, reload;
  logic [ROW_IDX_WIDTH-1:0] next_idx;

  // Row handshake: a row transfers on any cycle with row_valid && row_ready; once
  // row_valid is raised it stays high, and row_data/row_idx/row_last hold, until it does.
  assign capture_edge = valid_n_q && !matrix_valid_n;
  assign handshake    = row_valid && row_ready;
  assign last_hs      = handshake && row_last;

`ifdef SOFTMAX_ROW_STREAMER_DBUF_EN
  assign in_ready = !pending_full || last_hs;
`else
  assign in_ready = (state == ST_IDLE) || last_hs;
`endif

  // A matrix accepted on the final handshake goes straight to active unless one is already queued.
  assign accept    = capture_edge && in_ready;
  assign load_in   = accept && ((state == ST_IDLE) || (last_hs && !pending_full));
  assign load_pend = last_hs && pending_full;
  assign pend_wr   = accept && (state == ST_STREAM) && !(last_hs && !pending_full);
  assign pend_clr  = load_pend && !pend_wr;
  assign shift     = handshake && !load_in && !load_pend;
  assign reload    = load_in || load_pend;
  assign next_idx  = row_idx + ROW_IDX_WIDTH'(1);

  matrix_capture_buffer #(
    .ROW_BITS    (ROW_BITS),
    .MATRIX_ROWS (MATRIX_ROWS)
  ) u_buf (
    .clk          (clk_p),
    .rst          (rst_p),
    .matrix       (matrix),
    .load_in      (load_in),
    .load_pend    (load_pend),
    .shift        (shift),
    .pend_wr      (pend_wr),
    .pend_clr     (pend_clr),
    .row_data     (row_data),
    .pending_full (pending_full)
  );

  always_ff @(posedge clk_p) begin
    if (rst_p) begin
      state     <= ST_IDLE;
      row_valid <= 1'b0;
      row_idx   <= '0;
      row_last  <= 1'b0;
      overflow  <= 1'b0;
      valid_n_q <= 1'b1;
    end else begin
      valid_n_q <= matrix_valid_n;
      overflow  <= capture_edge && !in_ready;
      case (state)
        ST_IDLE: begin
          if (load_in) begin
            state     <= ST_STREAM;
            row_valid <= 1'b1;
            row_idx   <= '0;
            row_last  <= (LAST_IDX == '0);
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (reload) begin
              row_idx  <= '0;
              row_last <= (LAST_IDX == '0);
            end else if (last_hs) begin
              state     <= ST_IDLE;
              row_valid <= 1'b0;
              row_idx   <= '0;
              row_last  <= 1'b0;
            end else begin
              row_idx  <= next_idx;
              row_last <= (next_idx == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_STREAM) || pending_full;
  assign dbg_state = state;

endmodule

// File: tb/tb_softmax_row_streamer.sv
// Directed bench for softmax_row_streamer with a 4x2 matrix of bytes.
// Honours SOFTMAX_ROW_STREAMER_DBUF_EN for the second-edge scenario.
module tb_softmax_row_streamer;

  localparam int DW = 8, ROWS = 4, COLS = 2, RW = 16, MW = 64, IW = 2;
  localparam logic [MW-1:0] MA = 64'h0807_0605_0403_0201;
  localparam logic [MW-1:0] MB = 64'h1817_1615_1413_1211;
  localparam logic [MW-1:0] MC = 64'h2827_2625_2423_2221;

  // clock / reset
  logic clk_p = 1'b0;
  always #5 clk_p = ~clk_p;
  logic rst_p = 1'b1;

  logic [MW-1:0] matrix = '0;
  logic          matrix_valid_n = 1'b1;
  logic          row_ready = 1'b0;
  logic          in_ready, row_last, row_valid, busy, overflow;
  logic [RW-1:0] row_data;
  logic [IW-1:0] row_idx;
  softmax_stream_pkg::state_t dbg_state;

  softmax_row_streamer #(
    .DATA_WIDTH  (DW),
    .MATRIX_ROWS (ROWS),
    .MATRIX_COLS (COLS)
  ) dut (
    .clk_p          (clk_p),
    .rst_p          (rst_p),
    .matrix         (matrix),
    .matrix_valid_n (matrix_valid_n),
    .in_ready       (in_ready),
    .row_data       (row_data),
    .row_idx        (row_idx),
    .row_last       (row_last),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .busy           (busy),
    .overflow       (overflow),
    .dbg_state      (dbg_state)
  );

  int tests = 0, fails = 0, cyc_n = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  logic [IW-1:0] got_idx[$];
  logic          got_last[$];
  int            got_cyc[$];
  int            ovf_cnt, ovf_cyc;
  logic          s_valid, s_last, s_in_ready, s_busy, s_ovf;
  logic [RW-1:0] s_data;
  logic [IW-1:0] s_idx;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, tests=%0d", tests);
    $fatal(1);
  end

  task automatic clear_log();
    got_q.delete(); got_idx.delete(); got_last.delete(); got_cyc.delete();
    exp_q.delete();
    ovf_cnt = 0; ovf_cyc = -1;
  endtask

  // driver: apply inputs just after a rising edge, sample, record the handshake, advance
  task automatic drive_cycle(input logic rdy, input logic vn, input logic [MW-1:0] mat);
    row_ready = rdy; matrix_valid_n = vn; matrix = mat;
    #1;
    s_valid = row_valid; s_data = row_data; s_idx = row_idx; s_last = row_last;
    s_in_ready = in_ready; s_busy = busy; s_ovf = overflow;
    if (!rst_p && row_valid && row_ready) begin
      got_q.push_back(row_data); got_idx.push_back(row_idx);
      got_last.push_back(row_last); got_cyc.push_back(cyc_n);
    end
    if (overflow) begin ovf_cnt++; ovf_cyc = cyc_n; end
    @(posedge clk_p); #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    rst_p = 1'b1;
    drive_cycle(1'b0, 1'b1, MA);
    drive_cycle(1'b1, 1'b1, MA);
    tests++; if (row_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", row_valid); end
    tests++; if (row_data !== '0) begin fails++; $display("FAIL reset_data got=%h exp=0", row_data); end
    tests++; if (row_idx !== '0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", row_idx); end
    tests++; if (row_last !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", row_last); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (dbg_state !== softmax_stream_pkg::ST_IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst_p = 1'b0;
    drive_cycle(1'b0, 1'b1, '0);
  endtask

  task automatic test_basic_drain();
    int start;
    logic [IW-1:0] ei;
    clear_log();
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    start = cyc_n;
    drive_cycle(1'b1, 1'b0, MA);
    drive_cycle(1'b1, 1'b1, MA);
    tests++; if (dbg_state !== softmax_stream_pkg::ST_STREAM || !s_busy) begin fails++; $display("FAIL drain_streaming state=%0d busy=%b exp=1/1", dbg_state, s_busy); end
    for (int k = 0; k < 7; k++) drive_cycle(1'b1, 1'b1, MA);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL drain_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      ei = i[IW-1:0];
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      tests++; if (got_idx[i] !== ei) begin fails++; $display("FAIL drain_idx[%0d] got=%0d exp=%0d", i, got_idx[i], ei); end
      tests++; if (got_last[i] !== (i == 3)) begin fails++; $display("FAIL drain_last[%0d] got=%b exp=%b", i, got_last[i], (i == 3)); end
      tests++; if (got_cyc[i] != start + 1 + i) begin fails++; $display("FAIL drain_cycle[%0d] got=%0d exp=%0d", i, got_cyc[i], start + 1 + i); end
    end
    tests++; if (s_busy !== 1'b0 || s_in_ready !== 1'b1) begin fails++; $display("FAIL drain_idle busy=%b in_ready=%b exp=0/1", s_busy, s_in_ready); end
  endtask

  task automatic test_backpressure();
    logic          rdy, prev_stall;
    logic [RW-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    clear_log();
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    drive_cycle(1'b1, 1'b0, MA);
    prev_stall = 1'b0; prev_data = '0; prev_idx = '0;
    for (int k = 0; k < 20; k++) begin
      rdy = (k % 3 == 0);
      drive_cycle(rdy, 1'b1, MA);
      if (prev_stall) begin
        tests++;
        if (s_valid !== 1'b1 || s_data !== prev_data || s_idx !== prev_idx) begin
          fails++; $display("FAIL stall_hold k=%0d valid=%b data=%h idx=%0d exp=1/%h/%0d", k, s_valid, s_data, s_idx, prev_data, prev_idx);
        end
      end
      prev_stall = s_valid && !rdy; prev_data = s_data; prev_idx = s_idx;
    end
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i] || got_idx[i] !== i[IW-1:0]) begin fails++; $display("FAIL bp_row[%0d] got=%h/%0d exp=%h/%0d", i, got_q[i], got_idx[i], exp_q[i], i); end
    end
  endtask

  task automatic test_held_valid();
    clear_log();
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    for (int k = 0; k < 10; k++) drive_cycle(1'b1, 1'b0, MA);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, MA);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL held_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL held_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL held_overflow got=%0d exp=0", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    int start;
    clear_log();
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h1211, 16'h1413, 16'h1615, 16'h1817};
    start = cyc_n;
    drive_cycle(1'b1, 1'b0, MA);
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b1, MA);
    drive_cycle(1'b1, 1'b0, MB);
    tests++; if (s_in_ready !== 1'b1 || s_last !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got=%b last=%b exp=1/1", s_in_ready, s_last); end
    for (int k = 0; k < 8; k++) drive_cycle(1'b1, 1'b1, MB);
    tests++; if (got_q.size() != 8) begin fails++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i] || got_cyc[i] != start + 1 + i) begin fails++; $display("FAIL b2b_row[%0d] got=%h@%0d exp=%h@%0d", i, got_q[i], got_cyc[i], exp_q[i], start + 1 + i); end
    end
    tests++; if (ovf_cnt != 0) begin fails++; $display("FAIL b2b_overflow got=%0d exp=0", ovf_cnt); end
  endtask

  task automatic test_second_edge();
    int start;
    clear_log();
    start = cyc_n;
`ifdef SOFTMAX_ROW_STREAMER_DBUF_EN
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h1211, 16'h1413, 16'h1615, 16'h1817};
    drive_cycle(1'b1, 1'b0, MA);
    drive_cycle(1'b1, 1'b1, MA);
    drive_cycle(1'b1, 1'b0, MB);
    drive_cycle(1'b1, 1'b1, MB);
    drive_cycle(1'b0, 1'b0, MC);
    tests++; if (s_in_ready !== 1'b0 || s_busy !== 1'b1) begin fails++; $display("FAIL pend_full in_ready=%b busy=%b exp=0/1", s_in_ready, s_busy); end
    for (int k = 0; k < 10; k++) drive_cycle(1'b1, 1'b1, MC);
    tests++; if (got_q.size() != 8) begin fails++; $display("FAIL pend_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL pend_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() == 8) begin
      tests++; if (got_cyc[4] != got_cyc[3] + 1) begin fails++; $display("FAIL pend_bubble got=%0d exp=%0d", got_cyc[4], got_cyc[3] + 1); end
    end
    tests++; if (ovf_cnt != 1 || ovf_cyc != start + 5) begin fails++; $display("FAIL pend_overflow got=%0d@%0d exp=1@%0d", ovf_cnt, ovf_cyc, start + 5); end
`else
    exp_q = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
    drive_cycle(1'b1, 1'b0, MA);
    drive_cycle(1'b1, 1'b1, MA);
    drive_cycle(1'b1, 1'b0, MB);
    tests++; if (s_in_ready !== 1'b0) begin fails++; $display("FAIL ovf_in_ready got=%b exp=0", s_in_ready); end
    for (int k = 0; k < 6; k++) drive_cycle(1'b1, 1'b1, MB);
    tests++; if (got_q.size() != 4) begin fails++; $display("FAIL ovf_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== exp_q[i]) begin fails++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    tests++; if (ovf_cnt != 1 || ovf_cyc != start + 3) begin fails++; $display("FAIL ovf_pulse got=%0d@%0d exp=1@%0d", ovf_cnt, ovf_cyc, start + 3); end
`endif
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive_cycle(1'b1, 1'b0, MA);
    drive_cycle(1'b1, 1'b1, MA);
    drive_cycle(1'b1, 1'b1, MA);
    rst_p = 1'b1;
    drive_cycle(1'b1, 1'b1, MA);
    rst_p = 1'b0;
    drive_cycle(1'b1, 1'b1, MA);
    tests++;
    if (s_valid !== 1'b0 || s_data !== '0 || s_idx !== '0 || s_last !== 1'b0 || s_busy !== 1'b0 || s_ovf !== 1'b0 || s_in_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_outputs valid=%b data=%h idx=%0d last=%b busy=%b ovf=%b in_ready=%b exp=0/0/0/0/0/0/1", s_valid, s_data, s_idx, s_last, s_busy, s_ovf, s_in_ready);
    end
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, MA);
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL rst_mid_rows got=%0d exp=2", got_q.size()); end
  endtask

  initial begin
    @(posedge clk_p); #1;
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_held_valid();
    test_back_to_back();
    test_second_edge();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
